mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
Iterative multiply/divide unit for the MIPS-1 core, executing MULT/MULTU/DIV/DIVU and the HI/LO moves (MFHI/MTHI/MFLO/MTLO). It sits beside the ALU in the execute stage, decodes the R-type funct field itself, and uses a start/busy/done handshake so the pipeline stalls only while an operation runs. It is width-parametrised and multi-cycle, where the single-cycle ALU path is fixed-width and purely combinational.

Parameters:
- DATA_W, 32: operand, HI and LO width in bits; must be >= 4 and even.
- CNT_W, $clog2(DATA_W+1): iteration counter width; derived, not overridden.

Ports:
- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_n_i, input, 1: reset; synchronous and active-low.
- start_i, input, 1: issue request; sampled only in IDLE.
- funct_i, input, 6: R-type funct field, qualified by start_i.
- rs_i, input, DATA_W: operand A (dividend / multiplicand / MTxx source).
- rt_i, input, DATA_W: operand B (divisor / multiplier).
- busy_o, output, 1: high while MUL, DIV or FIX is active; the pipeline stalls on it.
- done_o, output, 1: one-cycle pulse when HI/LO are written by a mult/div.
- hi_o, output, DATA_W: HI register.
- lo_o, output, DATA_W: LO register.
- mf_data_o, output, DATA_W: combinational HI when funct_i=MFHI, LO when funct_i=MFLO, else 0.

Behaviour:
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Reset (rst_n_i=0 at an edge): state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter 0. This applies mid-operation too; the partial result is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start_i=1, MULT/MULTU: latch magnitudes (signed forms take abs; unsigned forms use raw operands) and record the result sign, then go to MUL. busy_o=1 from the next cycle.
- IDLE, start_i=1, DIV/DIVU: same latching, then go to DIV.
- IDLE, start_i=1, MTHI/MTLO: write rs_i into HI/LO at that edge, stay in IDLE. No busy, no done.
- IDLE, start_i=1, any other funct: ignored.
- MUL: one shift-add step per cycle for DATA_W cycles, producing a 2*DATA_W-bit product, then go to FIX.
- DIV: one restoring step per cycle for DATA_W cycles, then go to FIX.
- FIX (1 cycle): apply signs and write HI/LO; done_o=1 in the following cycle, state returns to IDLE.
- Signs: product negated if the operand signs differ. Quotient negated if the signs differ; remainder takes the dividend's sign.
- Results: mult gives HI = upper DATA_W bits, LO = lower DATA_W bits. Div gives LO = quotient, HI = remainder.
- Latency: start edge to HI/LO update is DATA_W+1 cycles. busy_o is high for exactly DATA_W+1 cycles. done_o pulses on the cycle busy_o falls.
- A new start_i may be accepted on the same cycle done_o is high.
- start_i while busy_o=1: ignored, no queuing.
- MFHI/MFLO: mf_data_o reflects registers as of the last edge. During busy, HI/LO hold their old values; the pipeline guarantees no read while busy.
- Divide by zero (rt_i=0): no trap. Full latency still applies. Result: LO = all ones, HI = rs_i for both DIV and DIVU. The FIX step must special-case this; raw restoring output is not acceptable.
- DIV of most-negative by -1: LO = most-negative (wraps), HI = 0.
- hi_o, lo_o, busy_o and done_o are all registered outputs.

Decomposition:
- Shared package mdu_pkg:
  - funct localparams listed above;
  - state enum (IDLE, MUL, DIV, FIX).
- Sub-module mdu_divstep: combinational one-step restoring divide (partial remainder, divisor in; next remainder and quotient bit out), parametrised by DATA_W.
- Multiply step and sign fix-up stay inline.

Test Plan (DATA_W=32):
- Reset held 2 cycles, then MTHI rs=0x1234_5678 and MTLO rs=0x9ABC_DEF0 -> hi_o/lo_o updated the next edge; busy_o stays 0; MFHI/MFLO return those values.
- MULT rs=-3 (0xFFFF_FFFD), rt=7 -> busy_o high for 33 cycles; done_o pulse; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. MULTU with the same operands -> HI=0x0000_0006, LO=0xFFFF_FFEB.
- DIV rs=-7, rt=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIVU rs=0x55, rt=0 -> LO=0xFFFF_FFFF, HI=0x55 after full latency. DIV 0x8000_0000 by -1 -> LO=0x8000_0000, HI=0.
- start_i held high with MULT during busy -> only one operation runs. Back-to-back start on the done_o cycle -> second operation accepted, and its done_o arrives 33 cycles later.
- rst_n_i low on cycle 10 of a DIV -> busy_o=0, hi_o=lo_o=0 after the edge; no done_o pulse.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: funct codes and FSM state type shared by the iterative multiply/divide unit.
package mdu_pkg;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one restoring-division step on unsigned magnitudes.
module mdu_divstep #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_q
);
    logic [DATA_W:0] w_shift;

    // The difference is always below the divisor, so DATA_W bits suffice.
    always_comb begin
        w_shift = {i_rem, i_bit};
        o_q     = w_shift >= {1'b0, i_div};
        o_rem   = o_q ? w_shift[DATA_W-1:0] - i_div : w_shift[DATA_W-1:0];
    end
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MIPS-1 MULT/MULTU/DIV/DIVU with HI/LO moves.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] mf_data_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a, r_q, r_rem, r_hi, r_lo;
    logic                r_neg_q, r_neg_r, r_dz, r_mul, r_busy, r_done;
    logic                w_is_mul, w_is_div, w_sa, w_sb, w_last, w_qbit;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_drem, w_quo, w_rmd;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;

    // Bit 0 of the mult/div funct codes selects the unsigned form.
    always_comb begin
        w_is_mul  = funct_i == F_MULT || funct_i == F_MULTU;
        w_is_div  = funct_i == F_DIV || funct_i == F_DIVU;
        w_sa      = ~funct_i[0] & rs_i[DATA_W-1];
        w_sb      = ~funct_i[0] & rt_i[DATA_W-1];
        w_mag_a   = w_sa ? -rs_i : rs_i;
        w_mag_b   = w_sb ? -rt_i : rt_i;
        w_last    = r_cnt == CNT_W'(DATA_W - 1);
        w_sum     = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_a} : '0);
        w_prod    = r_neg_q ? -{r_rem, r_q} : {r_rem, r_q};
        w_quo     = r_neg_q ? -r_q : r_q;
        w_rmd     = r_neg_r ? -r_rem : r_rem;
        mf_data_o = funct_i == F_MFHI ? r_hi : funct_i == F_MFLO ? r_lo : '0;
    end

    mdu_divstep #(.DATA_W(DATA_W)) u_divstep (
        .i_rem (r_rem),
        .i_bit (r_q[DATA_W-1]),
        .i_div (r_a),
        .o_rem (w_drem),
        .o_q   (w_qbit)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = !start_i ? IDLE : w_is_mul ? MUL : w_is_div ? DIV : IDLE;
            MUL:     w_state_nx = w_last ? FIX : MUL;
            DIV:     w_state_nx = w_last ? FIX : DIV;
            FIX:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // After DATA_W divide-by-zero steps r_rem holds the dividend magnitude,
    // so the signed remainder path already yields rs; only LO needs forcing.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_mul   <= 1'b0;
        end else begin
            r_busy <= w_state_nx != IDLE;
            r_done <= r_state == FIX;
            case (r_state)
                IDLE: if (start_i) begin
                    if (funct_i == F_MTHI) r_hi <= rs_i;
                    if (funct_i == F_MTLO) r_lo <= rs_i;
                    r_cnt   <= '0;
                    r_a     <= w_mag_b;
                    r_q     <= w_mag_a;
                    r_rem   <= '0;
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_dz    <= rt_i == '0;
                    r_mul   <= w_is_mul;
                end
                MUL: begin
                    r_cnt        <= r_cnt + 1'b1;
                    {r_rem, r_q} <= {w_sum, r_q[DATA_W-1:1]};
                end
                DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rem <= w_drem;
                    r_q   <= {r_q[DATA_W-2:0], w_qbit};
                end
                FIX: begin
                    r_hi <= r_mul ? w_prod[2*DATA_W-1:DATA_W] : w_rmd;
                    r_lo <= r_mul ? w_prod[DATA_W-1:0] : r_dz ? '1 : w_quo;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized and directed checks of mdu_iterative against an arithmetic model.
module tb_mdu_iterative;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_NONE  = 6'b000000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  funct_i = F_NONE;
    logic [31:0] rs_i = '0;
    logic [31:0] rt_i = '0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o, mf_data_o;

    int checks = 0;
    int errors = 0;

    mdu_iterative #(.DATA_W(32)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .funct_i   (funct_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .mf_data_o (mf_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: MIPS semantics from plain 64-bit arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            F_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic pulse(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        funct_i = f;
        rs_i = a;
        rt_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        funct_i = F_NONE;
    endtask

    // Ends on the negedge where busy_o has dropped (the done cycle, if any).
    task automatic wait_done(output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (!busy_o) begin
                if (done_o) done_cnt++;
                break;
            end
            busy_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt, output int done_cnt);
        @(negedge clk_i);
        pulse(f, a, b);
        wait_done(busy_cnt, done_cnt);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, hi_o, lo_o} !== 66'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, hi_o, lo_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_moves();
        pulse(F_MTHI, 32'h1234_5678, 32'h0);
        checks++;
        if (hi_o !== 32'h1234_5678 || lo_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b, want hi=12345678 lo=0 busy=0", hi_o, lo_o, busy_o);
        end
        pulse(F_MTLO, 32'h9ABC_DEF0, 32'h0);
        checks++;
        if (lo_o !== 32'h9ABC_DEF0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h busy=%b done=%b, want lo=9abcdef0 busy=0 done=0", lo_o, busy_o, done_o);
        end
        funct_i = F_MFHI;
        #1;
        checks++;
        if (mf_data_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mfhi: mf_data=%h, want 12345678", mf_data_o);
        end
        funct_i = F_MFLO;
        #1;
        checks++;
        if (mf_data_o !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mflo: mf_data=%h, want 9abcdef0", mf_data_o);
        end
        funct_i = F_MULT;
        #1;
        checks++;
        if (mf_data_o !== 32'h0) begin
            errors++;
            $display("FAIL mf_other: mf_data=%h, want 0", mf_data_o);
        end
        funct_i = F_NONE;
    endtask

    task automatic test_mult();
        int bc, dc;
        do_op(F_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
        checks++;
        if (bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL mult_timing: busy cycles=%0d done=%0d, want 33 and 1", bc, dc);
        end
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult: hi=%h lo=%h, want ffffffff ffffffeb", hi_o, lo_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, want 0", done_o);
        end
        do_op(F_MULTU, 32'hFFFF_FFFD, 32'd7, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== 64'h0000_0006_FFFF_FFEB || bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL multu: hi=%h lo=%h busy=%0d done=%0d, want 00000006 ffffffeb 33 1", hi_o, lo_o, bc, dc);
        end
    endtask

    task automatic test_div();
        int bc, dc;
        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFD || bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL div: hi=%h lo=%h busy=%0d done=%0d, want ffffffff fffffffd 33 1", hi_o, lo_o, bc, dc);
        end
        do_op(F_DIVU, 32'd100, 32'd7, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL divu: hi=%h lo=%h, want 2 and e", hi_o, lo_o);
        end
        do_op(F_DIVU, 32'h55, 32'h0, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== {32'h55, 32'hFFFF_FFFF} || bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL divu_zero: hi=%h lo=%h busy=%0d, want 00000055 ffffffff 33", hi_o, lo_o, bc);
        end
        do_op(F_DIV, 32'hFFFF_FF00, 32'h0, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== {32'hFFFF_FF00, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL div_zero: hi=%h lo=%h, want ffffff00 ffffffff", hi_o, lo_o);
        end
        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        checks++;
        if ({hi_o, lo_o} !== {32'h0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h, want 0 80000000", hi_o, lo_o);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [63:0] exp;
        logic [31:0] a, b;
        logic [5:0] f;
        int bc, dc;
        for (int n = 0; n < 40; n++) begin
            f = ops[$urandom_range(0, 3)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            exp = model(f, a, b);
            do_op(f, a, b, bc, dc);
            checks++;
            if ({hi_o, lo_o} !== exp || bc !== 33 || dc !== 1) begin
                errors++;
                $display("FAIL random f=%b a=%h b=%h: hi=%h lo=%h busy=%0d done=%0d, want %h %h 33 1",
                         f, a, b, hi_o, lo_o, bc, dc, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int bc, dc;
        logic [63:0] exp;
        exp = model(F_MULT, 32'd1000, 32'hFFFF_FFF6);
        @(negedge clk_i);
        start_i = 1'b1;
        funct_i = F_MULT;
        rs_i = 32'd1000;
        rt_i = 32'hFFFF_FFF6;
        @(negedge clk_i);
        rs_i = 32'd3;
        rt_i = 32'd5;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 80; i++) begin
            if (!busy_o) begin
                if (done_o) dc++;
                break;
            end
            bc++;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        funct_i = F_NONE;
        checks++;
        if ({hi_o, lo_o} !== exp || bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL busy_ignore: hi=%h lo=%h busy=%0d done=%0d, want %h %h 33 1",
                     hi_o, lo_o, bc, dc, exp[63:32], exp[31:0]);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_after: busy=%b after start dropped, want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        logic [63:0] exp;
        exp = model(F_DIV, 32'hFFFF_FC18, 32'd7);
        do_op(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, bc, dc);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL b2b_first: done=%0d, want 1", dc);
        end
        pulse(F_DIV, 32'hFFFF_FC18, 32'd7);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b after start on done cycle, want 1", busy_o);
        end
        wait_done(bc, dc);
        checks++;
        if ({hi_o, lo_o} !== exp || bc !== 33 || dc !== 1) begin
            errors++;
            $display("FAIL b2b_second: hi=%h lo=%h busy=%0d done=%0d, want %h %h 33 1",
                     hi_o, lo_o, bc, dc, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        @(negedge clk_i);
        pulse(F_DIV, 32'd12345, 32'd6);
        repeat (9) @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, hi_o, lo_o} !== 66'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, hi_o, lo_o);
        end
        rst_n_i = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) dc++;
        end
        checks++;
        if (dc !== 0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity=%0d hi=%h lo=%h, want 0 0 0", dc, hi_o, lo_o);
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_mult();
        test_div();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
